sbox_share_ctrl: RTL and testbench
==================================

// Module: sbox_share_ctrl
// PURPOSE
//  Shares a pool of NSBOX byte S-box instances between two requesters: the round datapath
//  (SubBytes on a 128-bit state) and key expansion (SubWord on a 32-bit word).
//  Each job is sequenced over ceil(bytes/NSBOX) beats, with round-robin arbitration at job
//  boundaries. Each requester has its own registered valid/ready response.
//  Sits between the AES round controller, the key scheduler and the sbox instances.
// PARAMETERS
//  NSBOX  4  number of sbox lanes instantiated; legal values 1,2,4,8,16
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  st_req_valid   in   1    state SubBytes request valid
//  st_req_ready   out  1    state request accepted when valid&ready
//  st_req_data    in   128  state; byte i = bits [8i+7:8i]
//  st_rsp_valid   out  1    substituted state available
//  st_rsp_ready   in   1    consumer accepts st_rsp_data
//  st_rsp_data    out  128  SubBytes(st_req_data), same byte order
//  key_req_valid  in   1    SubWord request valid
//  key_req_ready  out  1    key request accepted when valid&ready
//  key_req_data   in   32   word; byte i = bits [8i+7:8i]
//  key_rsp_valid  out  1    substituted word available
//  key_rsp_ready  in   1    consumer accepts key_rsp_data
//  key_rsp_data   out  32   SubWord(key_req_data)
//  busy           out  1    high in any RUN state
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, beat=0, last_grant=STATE, all *_valid=0, *_rsp_data=0, busy=0.
//    Reset mid-job discards the job; no partial response is ever presented.
//  - FSM states: IDLE, RUN_ST, RUN_KEY. Beat counts: B_ST=16/NSBOX; B_KEY=ceil(4/NSBOX).
//  - Eligibility: a requester is eligible in IDLE when its req_valid=1 and its rsp_valid=0.
//  - Arbitration (IDLE only): one eligible requester -> grant. Both eligible -> grant the one not in last_grant.
//  - req_ready for a requester = IDLE & rsp slot empty & granted-if-both-eligible.
//    req_ready never depends on that requester's own valid.
//  - Accept edge: latch req data into work reg, beat=0, FSM->RUN_x, last_grant<=x.
//  - Each RUN cycle: lane j takes work byte beat*NSBOX+j. For key with NSBOX>4, lanes 4.. are unused.
//    Outputs written into the rsp register byte slot. beat++.
//  - On the final beat edge: rsp_valid<=1 and FSM->IDLE. Rsp valid rises B edges after accept
//    (NSBOX=4: state 4, key 1).
//  - No preemption: a running job always completes.
//  - One IDLE cycle separates consecutive jobs.
//  - rsp_valid stays high and rsp_data stays stable until rsp_ready=1. rsp_valid clears on the handshake edge.
//  - A stalled response blocks only its own requester; the other requester continues to be served.
//  - rsp_valid&rsp_ready on the same edge that IDLE evaluates: the slot counts as still full
//    (no same-cycle refill); acceptance occurs the following cycle.
//  - The rsp register for a requester is written only by its own job.
//    The other slot is untouched by a running job.
//  - Beat counter width: $clog2(16/NSBOX)+1. Counter wraps to 0 on every job end.
//  - Lane mux and sbox instances are combinational. There is no combinational path from req_data to rsp_data.
// STRUCTURE
//  - Shared package aes_pkg holds AES_STATE_BYTES=16, AES_WORD_BYTES=4 and the FSM state
//    encoding localparams (IDLE/RUN_ST/RUN_KEY) plus the grant encoding (G_ST/G_KEY).
//  - NSBOX instances of the existing sbox module are placed in a generate loop. No new sub-module.
//  - The FSM, arbiter and beat counter live in this module.
// TESTING
//  1. State only, NSBOX=4: st_req_data=128'h0f0e0d0c0b0a09080706050403020100
//     -> st_rsp_valid 4 edges after accept, data=128'h76abd7fe2b670130c56f6bf27b777c63.
//  2. Key only: key_req_data=32'hcf4f3c09 -> key_rsp_valid 1 edge after accept, data=32'h8a84eb01.
//  3. Both valid in the first cycle after reset -> key granted first (last_grant=STATE).
//     State is accepted on the next IDLE cycle. Repeated simultaneous requests alternate grants.
//  4. st_rsp_ready=0 with a second state request pending -> st_req_ready stays 0 and st_rsp_data is held.
//     Key requests are still served. Raising st_rsp_ready lets the second state request be accepted
//     the following cycle.
//  5. rst_n pulsed low during beat 2 of a state job -> all valids and busy drop asynchronously.
//     After release, a key request (32'h00000000 -> 32'h63636363) completes normally.
//  6. Sweep NSBOX in {1,2,8,16} with vector 1 plus all-0xff (-> all-0x16).
//     Latency must equal 16/NSBOX for state and ceil(4/NSBOX) for key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and grant encoding used by
// the S-box sharing controller and its neighbours.
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;
    localparam int AES_WORD_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_ST  = 2'd1,
        RUN_KEY = 2'd2
    } state_t;

    typedef enum logic {
        G_ST  = 1'b0,
        G_KEY = 1'b1
    } grant_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/sbox_share_ctrl_sbox.sv
// Byte S-box (AES forward substitution), purely combinational.
// Computed as multiplicative inverse in GF(2^8) (x^254) followed by the
// AES affine transform, so there is no table to mistype.
//   in_byte   in   8   byte to substitute
//   out_byte  out  8   S(in_byte)
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    always_comb begin
        // addition chain to x^254; zero maps to zero naturally
        x2   = gf_mul(in_byte, in_byte);
        x3   = gf_mul(x2, in_byte);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares NSBOX byte S-box lanes between the round datapath (SubBytes, 16 bytes)
// and the key scheduler (SubWord, 4 bytes). Jobs run over several beats;
// arbitration is round-robin at job boundaries, each requester has its own
// registered response slot.
//   clk, rst_n                      clock, async active-low reset
//   st_req_valid/ready/data[127:0]  state request
//   st_rsp_valid/ready/data[127:0]  substituted state response
//   key_req_valid/ready/data[31:0]  key word request
//   key_rsp_valid/ready/data[31:0]  substituted word response
//   busy                            high while a job is running
//
// state   | meaning
// IDLE    | arbitrate and accept a request
// RUN_ST  | sequencing SubBytes beats
// RUN_KEY | sequencing SubWord beats
module sbox_share_ctrl
    import aes_pkg::*;
#(
    parameter int NSBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    input  logic         st_rsp_ready,
    output logic [127:0] st_rsp_data,
    input  logic         key_req_valid,
    output logic         key_req_ready,
    input  logic [31:0]  key_req_data,
    output logic         key_rsp_valid,
    input  logic         key_rsp_ready,
    output logic [31:0]  key_rsp_data,
    output logic         busy
);

    localparam int B_ST  = AES_STATE_BYTES / NSBOX;
    localparam int B_KEY = ceil_div(AES_WORD_BYTES, NSBOX);
    localparam int BW    = $clog2(B_ST) + 1;
    localparam logic [BW-1:0] LAST_ST  = BW'(B_ST - 1);
    localparam logic [BW-1:0] LAST_KEY = BW'(B_KEY - 1);

    state_t         state, state_next;
    grant_t         last_grant;
    logic [BW-1:0]  beat;
    logic [127:0]   work;
    logic [3:0]     lane_idx [NSBOX];
    logic [7:0]     lane_in  [NSBOX];
    logic [7:0]     lane_out [NSBOX];
    logic           st_elig, key_elig, st_acc, key_acc, is_last;

    // A full response slot makes its requester ineligible; ready is gated only
    // by the other side's eligibility so it never depends on its own valid.
    assign st_elig       = st_req_valid  & ~st_rsp_valid;
    assign key_elig      = key_req_valid & ~key_rsp_valid;
    assign st_req_ready  = (state == IDLE) & ~st_rsp_valid  & ~(key_elig & (last_grant == G_ST));
    assign key_req_ready = (state == IDLE) & ~key_rsp_valid & ~(st_elig  & (last_grant == G_KEY));
    assign st_acc        = st_req_valid  & st_req_ready;
    assign key_acc       = key_req_valid & key_req_ready;
    assign is_last       = ((state == RUN_ST)  && (beat == LAST_ST))
                         | ((state == RUN_KEY) && (beat == LAST_KEY));
    assign busy          = (state != IDLE);

    always_comb begin
        for (int j = 0; j < NSBOX; j++) begin
            lane_idx[j] = 4'(int'(beat) * NSBOX + j);
            lane_in[j]  = work[8*lane_idx[j] +: 8];
        end
    end

    for (genvar j = 0; j < NSBOX; j++) begin : g_lane
        sbox u_sbox (
            .in_byte  (lane_in[j]),
            .out_byte (lane_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (st_acc)       state_next = RUN_ST;
                else if (key_acc) state_next = RUN_KEY;
            end
            RUN_ST, RUN_KEY: begin
                if (is_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat          <= '0;
            last_grant    <= G_ST;
            work          <= '0;
            st_rsp_valid  <= 1'b0;
            st_rsp_data   <= '0;
            key_rsp_valid <= 1'b0;
            key_rsp_data  <= '0;
        end else begin
            if (st_acc) begin
                work       <= st_req_data;
                beat       <= '0;
                last_grant <= G_ST;
            end else if (key_acc) begin
                work       <= {96'd0, key_req_data};
                beat       <= '0;
                last_grant <= G_KEY;
            end

            if (state == RUN_ST || state == RUN_KEY) begin
                beat <= is_last ? '0 : beat + BW'(1);
            end

            if (state == RUN_ST) begin
                for (int j = 0; j < NSBOX; j++)
                    st_rsp_data[8*lane_idx[j] +: 8] <= lane_out[j];
            end

            // lanes beyond the 4-byte word are idle for key jobs
            if (state == RUN_KEY) begin
                for (int j = 0; j < NSBOX; j++)
                    if (lane_idx[j] < 4'(AES_WORD_BYTES))
                        key_rsp_data[8*lane_idx[j][1:0] +: 8] <= lane_out[j];
            end

            if (state == RUN_ST && is_last)     st_rsp_valid <= 1'b1;
            else if (st_rsp_valid && st_rsp_ready) st_rsp_valid <= 1'b0;

            if (state == RUN_KEY && is_last)      key_rsp_valid <= 1'b1;
            else if (key_rsp_valid && key_rsp_ready) key_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl. Instance 0 uses NSBOX=4 and carries the
// functional scenarios; instances 1..4 (NSBOX 1,2,8,16) share the stimulus and
// are checked in the latency/data sweep.
module tb_sbox_share_ctrl;

    localparam int NDUT = 5;
    localparam logic [127:0] V1_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] V1_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] VF_IN  = {16{8'hff}};
    localparam logic [127:0] VF_OUT = {16{8'h16}};

    function automatic int ns_of(input int g);
        case (g)
            0: return 4;
            1: return 1;
            2: return 2;
            3: return 8;
            default: return 16;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_req_valid = 1'b0;
    logic [127:0] st_req_data = '0;
    logic         st_rsp_ready = 1'b0;
    logic         key_req_valid = 1'b0;
    logic [31:0]  key_req_data = '0;
    logic         key_rsp_ready = 1'b0;

    logic         st_req_ready_a  [NDUT];
    logic         st_rsp_valid_a  [NDUT];
    logic [127:0] st_rsp_data_a   [NDUT];
    logic         key_req_ready_a [NDUT];
    logic         key_rsp_valid_a [NDUT];
    logic [31:0]  key_rsp_data_a  [NDUT];
    logic         busy_a          [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sbox_share_ctrl #(.NSBOX(ns_of(g))) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .st_req_valid  (st_req_valid),
            .st_req_ready  (st_req_ready_a[g]),
            .st_req_data   (st_req_data),
            .st_rsp_valid  (st_rsp_valid_a[g]),
            .st_rsp_ready  (st_rsp_ready),
            .st_rsp_data   (st_rsp_data_a[g]),
            .key_req_valid (key_req_valid),
            .key_req_ready (key_req_ready_a[g]),
            .key_req_data  (key_req_data),
            .key_rsp_valid (key_rsp_valid_a[g]),
            .key_rsp_ready (key_rsp_ready),
            .key_rsp_data  (key_rsp_data_a[g]),
            .busy          (busy_a[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        st_req_valid = 1'b0;
        key_req_valid = 1'b0;
        st_rsp_ready = 1'b0;
        key_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one request to instance 0, wait for acceptance, return edges to rsp_valid.
    task automatic run_job(input bit is_key, input logic [127:0] d, output int lat);
        int n = 0;
        @(negedge clk);
        if (is_key) begin key_req_valid = 1'b1; key_req_data = d[31:0]; end
        else        begin st_req_valid  = 1'b1; st_req_data  = d;       end
        #1;
        while (!(is_key ? key_req_ready_a[0] : st_req_ready_a[0]) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1;
        if (is_key) key_req_valid = 1'b0; else st_req_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (is_key ? key_rsp_valid_a[0] : st_rsp_valid_a[0]) begin lat = i; break; end
        end
    endtask

    task automatic pop_all();
        @(negedge clk); st_rsp_ready = 1'b1; key_rsp_ready = 1'b1;
        @(negedge clk); st_rsp_ready = 1'b0; key_rsp_ready = 1'b0;
    endtask

    task automatic sweep(input bit is_key, input logic [127:0] d, input logic [127:0] exp, input string name);
        int lat [NDUT];
        int want;
        @(negedge clk);
        if (is_key) begin key_req_valid = 1'b1; key_req_data = d[31:0]; end
        else        begin st_req_valid  = 1'b1; st_req_data  = d;       end
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("%s_ready_ns%0d", name, ns_of(i)),
                  is_key ? key_req_ready_a[i] : st_req_ready_a[i], 1);
        @(posedge clk); #1;
        key_req_valid = 1'b0; st_req_valid = 1'b0;
        for (int i = 0; i < NDUT; i++) lat[i] = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++)
                if (lat[i] < 0 && (is_key ? key_rsp_valid_a[i] : st_rsp_valid_a[i])) lat[i] = c;
        end
        for (int i = 0; i < NDUT; i++) begin
            want = is_key ? ((ns_of(i) >= 4) ? 1 : 4 / ns_of(i)) : 16 / ns_of(i);
            check($sformatf("%s_lat_ns%0d", name, ns_of(i)), lat[i], want);
            check($sformatf("%s_data_ns%0d", name, ns_of(i)),
                  is_key ? {96'd0, key_rsp_data_a[i]} : st_rsp_data_a[i], exp);
        end
        pop_all();
    endtask

    initial begin
        int lat;
        int gcyc [4];
        bit gkey [4];
        int ng;

        // 1: reset values, state job
        do_reset();
        @(negedge clk); #1;
        check("rst_st_rsp_valid",  st_rsp_valid_a[0], 0);
        check("rst_key_rsp_valid", key_rsp_valid_a[0], 0);
        check("rst_busy",          busy_a[0], 0);
        check("rst_st_rsp_data",   st_rsp_data_a[0], 0);
        check("rst_key_rsp_data",  key_rsp_data_a[0], 0);
        check("rst_st_req_ready",  st_req_ready_a[0], 1);
        check("rst_key_req_ready", key_req_ready_a[0], 1);
        run_job(0, V1_IN, lat);
        check("st_lat", lat, 4);
        check("st_data", st_rsp_data_a[0], V1_OUT);
        check("st_busy_done", busy_a[0], 0);
        pop_all();
        check("st_valid_cleared", st_rsp_valid_a[0], 0);

        // 2: key job
        run_job(1, 128'hcf4f3c09, lat);
        check("key_lat", lat, 1);
        check("key_data", key_rsp_data_a[0], 32'h8a84eb01);
        pop_all();

        // 3: simultaneous requests alternate, key first after reset
        do_reset();
        st_rsp_ready = 1'b1; key_rsp_ready = 1'b1;
        st_req_data = V1_IN; key_req_data = 32'hcf4f3c09;
        st_req_valid = 1'b1; key_req_valid = 1'b1;
        #1;
        check("arb_first_key_ready", key_req_ready_a[0], 1);
        check("arb_first_st_ready",  st_req_ready_a[0], 0);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            if (key_req_ready_a[0])     begin gkey[ng] = 1'b1; gcyc[ng] = c; ng++; end
            else if (st_req_ready_a[0]) begin gkey[ng] = 1'b0; gcyc[ng] = c; ng++; end
            @(negedge clk); #1;
        end
        st_req_valid = 1'b0; key_req_valid = 1'b0;
        check("arb_grant_count", ng, 4);
        check("arb_order", {gkey[0], gkey[1], gkey[2], gkey[3]}, 4'b1010);
        check("arb_st_gap", gcyc[1] - gcyc[0], 2);
        repeat (8) @(negedge clk);
        check("arb_st_data", st_rsp_data_a[0], V1_OUT);
        st_rsp_ready = 1'b0; key_rsp_ready = 1'b0;

        // 4: stalled state response blocks only the state requester
        do_reset();
        run_job(0, V1_IN, lat);
        check("stall_first_lat", lat, 4);
        @(negedge clk);
        st_req_valid = 1'b1; st_req_data = VF_IN;
        #1;
        check("stall_st_ready", st_req_ready_a[0], 0);
        key_rsp_ready = 1'b1;
        run_job(1, 128'hcf4f3c09, lat);
        check("stall_key_lat", lat, 1);
        check("stall_key_data", key_rsp_data_a[0], 32'h8a84eb01);
        repeat (3) @(negedge clk);
        #1;
        check("stall_st_ready_held", st_req_ready_a[0], 0);
        check("stall_st_valid_held", st_rsp_valid_a[0], 1);
        check("stall_st_data_held",  st_rsp_data_a[0], V1_OUT);
        st_rsp_ready = 1'b1;
        #1;
        check("stall_no_same_cycle_refill", st_req_ready_a[0], 0);
        @(posedge clk); #1;
        st_rsp_ready = 1'b0;
        check("stall_valid_cleared", st_rsp_valid_a[0], 0);
        check("stall_refill_ready", st_req_ready_a[0], 1);
        @(posedge clk); #1;
        st_req_valid = 1'b0;
        check("stall_second_busy", busy_a[0], 1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (st_rsp_valid_a[0]) begin lat = i; break; end
        end
        check("stall_second_lat", lat, 4);
        check("stall_second_data", st_rsp_data_a[0], VF_OUT);
        key_rsp_ready = 1'b0;
        pop_all();

        // 5: async reset during beat 2 of a state job
        do_reset();
        @(negedge clk);
        st_req_valid = 1'b1; st_req_data = V1_IN;
        @(posedge clk); #1;
        st_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("arst_busy_before", busy_a[0], 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_a[0], 0);
        check("arst_st_valid", st_rsp_valid_a[0], 0);
        check("arst_key_valid", key_rsp_valid_a[0], 0);
        check("arst_st_data", st_rsp_data_a[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(1, 128'h0, lat);
        check("arst_key_lat", lat, 1);
        check("arst_key_data", key_rsp_data_a[0], 32'h63636363);
        repeat (6) @(posedge clk);
        #1;
        check("arst_no_partial_st", st_rsp_valid_a[0], 0);
        pop_all();

        // 6: NSBOX sweep
        do_reset();
        sweep(0, V1_IN, V1_OUT, "sw_st_v1");
        sweep(0, VF_IN, VF_OUT, "sw_st_ff");
        sweep(1, 128'hcf4f3c09, 128'h8a84eb01, "sw_key_v2");
        sweep(1, 128'hffffffff, 128'h16161616, "sw_key_ff");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
